bin2bcd_seq: RTL and testbench

//  Iterative (shift-add-3 / double-dabble) binary-to-BCD converter feeding the 4-digit SSD display driver.

---
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter for the SSD display path.
// One input bit is shifted per cycle; result and overflow are registered and held until the next done.
module bin2bcd_seq #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   shreg_reg;
    logic [BCD_W-1:0]   scratch_reg;
    logic               ovf_sticky_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               done_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic               ovf_reg;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W+WIDTH:0]   shifted;
    logic [BCD_W-1:0]       scratch_next;
    logic [WIDTH-1:0]       shreg_next;
    logic                   ovf_next;

    // Add-3 correction on every digit, all taken from the pre-shift scratch value.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                    scratch_reg[4*gi +: 4] + 4'd3 :
                                    scratch_reg[4*gi +: 4];
        end
    endgenerate

    // The bit leaving the top digit is the overflow carry.
    assign shifted      = {1'b0, adj, shreg_reg} << 1;
    assign scratch_next = shifted[WIDTH +: BCD_W];
    assign shreg_next   = shifted[WIDTH-1:0];
    assign ovf_next     = ovf_sticky_reg | shifted[BCD_W+WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            scratch_reg    <= '0;
            ovf_sticky_reg <= 1'b0;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            bcd_reg        <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        shreg_reg      <= bin;
                        scratch_reg    <= '0;
                        ovf_sticky_reg <= 1'b0;
                        cnt_reg        <= CNT_LOAD;
                        state_reg      <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg_reg      <= shreg_next;
                    scratch_reg    <= scratch_next;
                    ovf_sticky_reg <= ovf_next;
                    if (cnt_reg == '0) begin
                        // Results are taken from the final shift so they appear in the DONE cycle.
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        bcd_reg   <= ovf_next ? NINES : scratch_next;
                        ovf_reg   <= ovf_next;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 13-bit and a 16-bit instance share one stimulus stream
// and are compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin16;
    logic        busy13, done13, ovf13;
    logic        busy16, done16, ovf16;
    logic [15:0] bcd13, bcd16;

    int checks = 0;
    int errors = 0;
    int done13_cnt = 0, done16_cnt = 0;
    int exp_done13 = 0, exp_done16 = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(13), .DIGITS(4)) dut13 (
        .clk(clk), .rst(rst), .start(start), .bin(bin16[12:0]),
        .busy(busy13), .done(done13), .bcd(bcd13), .ovf(ovf13)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16)
    );

    always @(posedge clk) begin
        if (done13) done13_cnt++;
        if (done16) done16_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] val;
        logic [15:0] exp13;
        logic        exp_ovf13;
        logic [15:0] exp16;
        logic        exp_ovf16;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Decimal digits by plain division; saturates to all nines above 9999.
    function automatic void ref_model(input int v, output logic [15:0] b, output logic o);
        int x;
        b = '0;
        o = (v > 9999);
        if (o) begin
            b = 16'h9999;
        end else begin
            x = v;
            for (int d = 0; d < 4; d++) begin
                b[4*d +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
    endfunction

    // One conversion on both instances; checks latency, busy length, result and single done pulse.
    task automatic run(input logic [15:0] v, input logic [15:0] e13, input logic o13,
                       input logic [15:0] e16, input logic o16);
        int t13, t16, busy_n, p13, p16;
        logic [15:0] g13, g16;
        logic go13, go16;
        t13 = -1; t16 = -1; busy_n = 0; p13 = 0; p16 = 0;
        g13 = '0; g16 = '0; go13 = 1'b0; go16 = 1'b0;
        @(negedge clk); bin16 = v; start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (busy13) busy_n++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy13) busy_n++;
            if (done13) begin
                p13++;
                if (t13 < 0) begin t13 = k; g13 = bcd13; go13 = ovf13; end
            end
            if (done16) begin
                p16++;
                if (t16 < 0) begin t16 = k; g16 = bcd16; go16 = ovf16; end
            end
        end
        exp_done13++; exp_done16++;
        chk("lat13", t13, 13);
        chk("lat16", t16, 16);
        chk("busy13_len", busy_n, 13);
        chk("bcd13", g13, e13);
        chk("ovf13", go13, o13);
        chk("bcd16", g16, e16);
        chk("ovf16", go16, o16);
        chk("pulses13", p13, 1);
        chk("pulses16", p16, 1);
        $display("conv bin=%0d w13 bcd=%h ovf=%0b lat=%0d | w16 bcd=%h ovf=%0b lat=%0d",
                 v, g13, go13, t13, g16, go16, t16);
    endtask

    task automatic run_rand(input logic [15:0] v);
        logic [15:0] e13, e16;
        logic o13, o16;
        ref_model(int'(v) % 8192, e13, o13);
        ref_model(int'(v), e16, o16);
        run(v, e13, o13, e16, o16);
    endtask

    vec_t vecs[9];
    int   q_t[$];
    logic [15:0] q_b[$];
    int   n16, late;

    initial begin
        vecs[0] = '{16'd1234,  16'h1234, 1'b0, 16'h1234, 1'b0};
        vecs[1] = '{16'd0,     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{16'd8191,  16'h8191, 1'b0, 16'h8191, 1'b0};
        vecs[3] = '{16'd9,     16'h0009, 1'b0, 16'h0009, 1'b0};
        vecs[4] = '{16'd10,    16'h0010, 1'b0, 16'h0010, 1'b0};
        vecs[5] = '{16'd12345, 16'h4153, 1'b0, 16'h9999, 1'b1};
        vecs[6] = '{16'd9999,  16'h1807, 1'b0, 16'h9999, 1'b0};
        vecs[7] = '{16'd10000, 16'h1808, 1'b0, 16'h9999, 1'b1};
        vecs[8] = '{16'd65535, 16'h8191, 1'b0, 16'h9999, 1'b1};

        rst = 1'b1; start = 1'b0; bin16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy13", busy13, 0);
        chk("rst_done13", done13, 0);
        chk("rst_bcd13", bcd13, 0);
        chk("rst_ovf13", ovf13, 0);
        chk("rst_busy16", busy16, 0);
        chk("rst_bcd16", bcd16, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run(vecs[i].val, vecs[i].exp13, vecs[i].exp_ovf13, vecs[i].exp16, vecs[i].exp_ovf16);

        // Start held high: bin change mid-SHIFT is ignored, restart in the DONE cycle picks it up.
        n16 = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            start = (k < 40);
            bin16 = (k < 5) ? 16'd4321 : 16'd77;
            @(posedge clk); #1;
            if (done13) begin q_t.push_back(k); q_b.push_back(bcd13); end
            if (done16) n16++;
        end
        start = 1'b0;
        exp_done13 += 3; exp_done16 += 3;
        chk("b2b_count13", q_t.size(), 3);
        chk("b2b_count16", n16, 3);
        if (q_t.size() >= 2) begin
            chk("b2b_t0", q_t[0], 13);
            chk("b2b_bcd0", q_b[0], 16'h4321);
            chk("b2b_gap", q_t[1] - q_t[0], 14);
            chk("b2b_bcd1", q_b[1], 16'h0077);
        end
        $display("conv back-to-back dones=%0d", q_t.size());

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk); bin16 = 16'd555; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy13", busy13, 0);
        chk("abort_bcd13", bcd13, 0);
        chk("abort_done13", done13, 0);
        chk("abort_busy16", busy16, 0);
        chk("abort_bcd16", bcd16, 0);
        @(negedge clk); rst = 1'b0;
        late = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done13 || done16) late++;
        end
        chk("abort_no_done", late, 0);
        $display("conv aborted bin=555 late_dones=%0d", late);

        for (int i = 0; i < 120; i++) run_rand(16'($urandom_range(0, 8191)));
        for (int i = 0; i < 40; i++)  run_rand(16'($urandom_range(0, 65535)));

        repeat (3) @(posedge clk);
        chk("done13_total", done13_cnt, exp_done13);
        chk("done16_total", done16_cnt, exp_done16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
